// File: rtl/reaction_arbiter_pkg.sv
// Shared types and constants for the reaction arbiter: FSM encoding,
// player indices and the tie winner code.
package reaction_arbiter_pkg;

  typedef enum logic [1:0] {
    WAIT_CD = 2'd0,
    ARMED   = 2'd1,
    DONE    = 2'd2
  } state_e;

  localparam int PLAYER_A = 0;
  localparam int PLAYER_B = 1;

  localparam logic [1:0] WINNER_TIE = 2'b11;

  // One-hot code of the opponent of a single one-hot player code.
  function automatic logic [1:0] other_player(input logic [1:0] player);
    return {player[PLAYER_A], player[PLAYER_B]};
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// Conditions one raw pushbutton: multi-flop synchroniser, saturating
// debounce counter and a one-cycle press pulse on acceptance.
// SYNC_STAGES must be 2 or more; DEBOUNCE_COUNT must be 2 or more.
module button_conditioner #(
  parameter int SYNC_STAGES    = 2,
  parameter int DEBOUNCE_COUNT = 120000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press_evt_out
);

  localparam int CNT_W = $clog2(DEBOUNCE_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_COUNT - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   pressed_q, pressed_d;
  logic                   pressed_prev_q, pressed_prev_d;
  logic                   sync_out;
  logic                   cnt_sat;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign cnt_sat  = (cnt_q == CNT_MAX);

  // Next-state: shift the synchroniser, run the saturating counter and
  // accept a press once the counter is saturated and the input is still high,
  // i.e. after DEBOUNCE_COUNT consecutive high synchronised samples.
  always_comb begin
    sync_d         = {sync_q[SYNC_STAGES-2:0], btn_raw};
    cnt_d          = cnt_q;
    pressed_d      = sync_out && cnt_sat;
    pressed_prev_d = pressed_q;
    if (!sync_out) begin
      cnt_d = '0;
    end else if (!cnt_sat) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Conditioning registers, all cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q         <= '0;
      cnt_q          <= '0;
      pressed_q      <= 1'b0;
      pressed_prev_q <= 1'b0;
    end else begin
      sync_q         <= sync_d;
      cnt_q          <= cnt_d;
      pressed_q      <= pressed_d;
      pressed_prev_q <= pressed_prev_d;
    end
  end

  assign press_evt_out = pressed_q && !pressed_prev_q;

endmodule

// File: rtl/reaction_arbiter.sv
// Reaction-game arbiter: conditions both player buttons, decides
// win / foul / tie against the countdown-done flag and holds the result
// until the next reset.
module reaction_arbiter
  import reaction_arbiter_pkg::*;
#(
  parameter int CLOCK_FREQ     = 12000000,
  parameter int SYNC_STAGES    = 2,
  parameter int DEBOUNCE_COUNT = CLOCK_FREQ / 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cd_done_in,
  input  logic [1:0] btn_in,
  output logic [1:0] winner_out,
  output logic [1:0] foul_out,
  output logic       tie_out,
  output logic       result_valid_out
);

  logic [1:0] press_evt;
  state_e     state_q, state_d;
  logic [1:0] winner_q, winner_d;
  logic [1:0] foul_q, foul_d;
  logic       tie_q, tie_d;

  button_conditioner #(
    .SYNC_STAGES   (SYNC_STAGES),
    .DEBOUNCE_COUNT(DEBOUNCE_COUNT)
  ) u_cond_a (
    .clk          (clk),
    .reset        (reset),
    .btn_raw      (btn_in[PLAYER_A]),
    .press_evt_out(press_evt[PLAYER_A])
  );

  button_conditioner #(
    .SYNC_STAGES   (SYNC_STAGES),
    .DEBOUNCE_COUNT(DEBOUNCE_COUNT)
  ) u_cond_b (
    .clk          (clk),
    .reset        (reset),
    .btn_raw      (btn_in[PLAYER_B]),
    .press_evt_out(press_evt[PLAYER_B])
  );

  // Round FSM: events are judged against the current state before any
  // WAIT_CD->ARMED move, so a press coinciding with countdown-done is a foul.
  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    foul_d   = foul_q;
    tie_d    = tie_q;
    case (state_q)
      WAIT_CD: begin
        if (press_evt == 2'b11) begin
          foul_d   = 2'b11;
          winner_d = 2'b00;
          state_d  = DONE;
        end else if (press_evt != 2'b00) begin
          foul_d   = press_evt;
          winner_d = other_player(press_evt);
          state_d  = DONE;
        end else if (cd_done_in) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (press_evt == 2'b11) begin
          winner_d = WINNER_TIE;
          tie_d    = 1'b1;
          state_d  = DONE;
        end else if (press_evt != 2'b00) begin
          winner_d = press_evt;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = WAIT_CD;
      end
    endcase
  end

  // State and outcome registers; reset starts a fresh round.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= WAIT_CD;
      winner_q <= 2'b00;
      foul_q   <= 2'b00;
      tie_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      foul_q   <= foul_d;
      tie_q    <= tie_d;
    end
  end

  assign winner_out       = winner_q;
  assign foul_out         = foul_q;
  assign tie_out          = tie_q;
  assign result_valid_out = (state_q == DONE);

endmodule

// File: tb/tb_reaction_arbiter.sv
// Self-checking bench for reaction_arbiter: directed round scenarios plus
// randomized rounds compared every cycle against a behavioural model.
module tb_reaction_arbiter;

  localparam int S = 2;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cd_done_in = 1'b0;
  logic [1:0] btn_in = 2'b00;
  logic [1:0] winner_out;
  logic [1:0] foul_out;
  logic       tie_out;
  logic       result_valid_out;

  int n_cmp = 0;
  int n_bad = 0;

  reaction_arbiter #(
    .CLOCK_FREQ    (12000000),
    .SYNC_STAGES   (S),
    .DEBOUNCE_COUNT(D)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .cd_done_in      (cd_done_in),
    .btn_in          (btn_in),
    .winner_out      (winner_out),
    .foul_out        (foul_out),
    .tie_out         (tie_out),
    .result_valid_out(result_valid_out)
  );

  always #5 clk = ~clk;

  // Behavioural model: raw samples delayed S edges, run length of
  // consecutive high samples, press when the run reaches D.
  bit         dq_a[$];
  bit         dq_b[$];
  int         run_a, run_b;
  bit         pend_a, pend_b;
  bit         m_armed, m_done;
  logic [1:0] m_win, m_foul;
  logic       m_tie;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic c, input logic [1:0] b);
    logic [1:0] ev;
    bit s;
    if (r) begin
      dq_a = {};
      dq_b = {};
      for (int i = 0; i < S; i++) begin
        dq_a.push_back(1'b0);
        dq_b.push_back(1'b0);
      end
      run_a = 0; run_b = 0; pend_a = 0; pend_b = 0;
      m_armed = 0; m_done = 0;
      m_win = 2'b00; m_foul = 2'b00; m_tie = 1'b0;
    end else begin
      ev = {pend_b, pend_a};
      if (!m_done) begin
        if (!m_armed) begin
          if (ev == 2'b11) begin
            m_foul = 2'b11; m_win = 2'b00; m_done = 1;
          end else if (ev != 2'b00) begin
            m_foul = ev; m_win = ~ev; m_done = 1;
          end else if (c) begin
            m_armed = 1;
          end
        end else begin
          if (ev == 2'b11) begin
            m_win = 2'b11; m_tie = 1'b1; m_done = 1;
          end else if (ev != 2'b00) begin
            m_win = ev; m_done = 1;
          end
        end
      end
      s = dq_a.pop_front(); dq_a.push_back(b[0]);
      run_a = s ? run_a + 1 : 0;
      pend_a = (run_a == D);
      s = dq_b.pop_front(); dq_b.push_back(b[1]);
      run_b = s ? run_b + 1 : 0;
      pend_b = (run_b == D);
    end
  endtask

  // One clock: drive on the falling edge, model the rising edge, sample after it.
  task automatic step(input logic r, input logic c, input logic [1:0] b);
    @(negedge clk);
    reset = r; cd_done_in = c; btn_in = b;
    @(posedge clk);
    model_edge(r, c, b);
    #1;
    chk("winner", {6'd0, winner_out}, {6'd0, m_win});
    chk("foul", {6'd0, foul_out}, {6'd0, m_foul});
    chk("tie", {7'd0, tie_out}, {7'd0, m_tie});
    chk("valid", {7'd0, result_valid_out}, {7'd0, m_done});
  endtask

  initial begin
    logic [1:0] lvl;
    int left_a, left_b;
    int cd_at;
    logic c;

    // Reset state
    step(1, 0, 2'b00);
    step(1, 0, 2'b00);
    chk("rst_winner", {6'd0, winner_out}, 8'h00);
    chk("rst_valid", {7'd0, result_valid_out}, 8'h00);

    // Player A false start
    for (int i = 1; i <= 10; i++) begin
      step(0, 0, 2'b01);
      if (i == 6) chk("t1_valid_early", {7'd0, result_valid_out}, 8'h00);
      if (i == 7) begin
        chk("t1_foul", {6'd0, foul_out}, 8'h01);
        chk("t1_winner", {6'd0, winner_out}, 8'h02);
        chk("t1_valid", {7'd0, result_valid_out}, 8'h01);
      end
    end

    // Player B wins after countdown
    step(1, 0, 2'b00);
    for (int i = 0; i < 3; i++) step(0, 1, 2'b00);
    for (int i = 1; i <= 8; i++) begin
      step(0, 1, 2'b10);
      if (i == 6) chk("t2_winner_early", {6'd0, winner_out}, 8'h00);
      if (i == 7) begin
        chk("t2_winner", {6'd0, winner_out}, 8'h02);
        chk("t2_foul", {6'd0, foul_out}, 8'h00);
        chk("t2_tie", {7'd0, tie_out}, 8'h00);
      end
    end

    // Tie
    step(1, 0, 2'b00);
    for (int i = 0; i < 3; i++) step(0, 1, 2'b00);
    for (int i = 0; i < 8; i++) step(0, 1, 2'b11);
    chk("t3_winner", {6'd0, winner_out}, 8'h03);
    chk("t3_tie", {7'd0, tie_out}, 8'h01);
    chk("t3_foul", {6'd0, foul_out}, 8'h00);

    // Short bounce gives no event
    step(1, 0, 2'b00);
    for (int i = 0; i < 3; i++) step(0, 1, 2'b00);
    for (int i = 0; i < 3; i++) step(0, 1, 2'b01);
    for (int i = 0; i < 10; i++) step(0, 1, 2'b00);
    chk("t4_winner", {6'd0, winner_out}, 8'h00);
    chk("t4_valid", {7'd0, result_valid_out}, 8'h00);

    // A wins, later B ignored, then reset clears
    step(1, 0, 2'b00);
    for (int i = 0; i < 2; i++) step(0, 1, 2'b00);
    for (int i = 0; i < 8; i++) step(0, 1, 2'b01);
    for (int i = 0; i < 10; i++) step(0, 1, 2'b10);
    chk("t5_hold_winner", {6'd0, winner_out}, 8'h01);
    step(1, 1, 2'b00);
    chk("t5_rst_winner", {6'd0, winner_out}, 8'h00);
    chk("t5_rst_valid", {7'd0, result_valid_out}, 8'h00);

    // B held through reset is a fresh foul
    step(1, 0, 2'b10);
    step(1, 0, 2'b10);
    for (int i = 1; i <= 7; i++) step(0, 0, 2'b10);
    chk("t6_foul", {6'd0, foul_out}, 8'h02);
    chk("t6_winner", {6'd0, winner_out}, 8'h01);

    // Randomized rounds
    for (int r = 0; r < 40; r++) begin
      lvl = 2'($urandom_range(0, 3));
      left_a = 0; left_b = 0;
      for (int k = 0; k < int'($urandom_range(1, 2)); k++) step(1, 0, lvl);
      cd_at = int'($urandom_range(0, 30));
      for (int cyc = 0; cyc < 60; cyc++) begin
        if (left_a == 0 && left_b == 0 && ($urandom % 6 == 0)) begin
          lvl = {2{1'($urandom)}};
          left_a = int'($urandom_range(1, 8));
          left_b = left_a;
        end
        if (left_a == 0) begin
          lvl[0] = 1'($urandom);
          left_a = int'($urandom_range(1, 8));
        end
        if (left_b == 0) begin
          lvl[1] = 1'($urandom);
          left_b = int'($urandom_range(1, 8));
        end
        c = (cyc >= cd_at) && ($urandom % 40 != 0);
        step(0, c, lvl);
        left_a--;
        left_b--;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reaction_arbiter.md
Name: reaction_arbiter

Overview:
- Sits directly downstream of the round countdown block and consumes its countdown-done flag.
- Conditions two player pushbuttons: synchronises, debounces and edge-detects each one.
- Decides the round outcome: first valid press after countdown-done wins, any press before it is a foul.
- Latches the outcome on the result LEDs until the next reset, which starts a new round.

Parameters:
- CLOCK_FREQ, 12000000, system clock frequency in Hz; kept for consistency with the countdown block.
- SYNC_STAGES, 2, flip-flop stages in each button synchroniser; must be 2 or more.
- DEBOUNCE_COUNT, CLOCK_FREQ/100, consecutive cycles of stable high input needed to accept a press (10 ms default).

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset; also starts a new round.
- cd_done_in  input  1  countdown finished; level, stays high until reset.
- btn_in  input  2  raw, asynchronous player buttons, active-high; bit 0 = player A, bit 1 = player B.
- winner_out  output  2  one-hot winner; 2'b11 on a tie.
- foul_out  output  2  per-player false-start flag.
- tie_out  output  1  both players pressed on the same cycle after the countdown.
- result_valid_out  output  1  high once the outcome is latched.

Behaviour:
- Reset is synchronous: every register is cleared on the first posedge clk with reset high.
- Reset values: winner_out=0, foul_out=0, tie_out=0, result_valid_out=0, FSM=WAIT_CD, synchronisers=0, debounce counters=0, pressed levels=0.
- Conditioning, per player:
  - SYNC_STAGES-flop synchroniser.
  - Counter increments while the synchronised input is 1 and clears to 0 on any 0 sample.
  - Counter saturates at DEBOUNCE_COUNT-1 and never wraps.
  - pressed level = 1 while the counter is saturated.
  - press event = one-cycle pulse on the 0->1 transition of pressed.
- Latency from a stable raw high to the press event is exactly SYNC_STAGES+DEBOUNCE_COUNT cycles. Outputs update one cycle after the event.
- FSM state WAIT_CD:
  - Single event from player i: foul_out[i]=1, winner_out=the other player, go to DONE.
  - Events from both players on the same cycle: foul_out=2'b11, winner_out=0, go to DONE.
  - No event and cd_done_in=1: go to ARMED.
  - An event on the same cycle as cd_done_in rising counts as a foul, because the state is evaluated before the transition.
- FSM state ARMED:
  - Single event from player i: winner_out[i]=1, go to DONE.
  - Events from both players on the same cycle: winner_out=2'b11, tie_out=1, go to DONE.
  - cd_done_in dropping without a reset is ignored; the FSM stays in ARMED.
- FSM state DONE:
  - result_valid_out=1; all outputs are frozen.
  - All further events and cd_done_in are ignored until reset.
- result_valid_out rises on the same cycle the outcome outputs first show their values.
- Button held through reset: the pressed level restarts at 0, so the held button produces a fresh event after the debounce time. In WAIT_CD that event is a foul.
- Reset mid-round: the FSM returns to WAIT_CD and the outcome outputs clear on the next edge.
- Bounce shorter than DEBOUNCE_COUNT produces no event.
- A release followed by a second press produces no second outcome; DONE is terminal.

Decomposition:
- Shared package holds:
  - FSM state encoding: WAIT_CD=2'd0, ARMED=2'd1, DONE=2'd2.
  - Player index constants: PLAYER_A=0, PLAYER_B=1.
  - Winner code for a tie: 2'b11.
- Sub-module button_conditioner:
  - Contains the synchroniser, saturating debounce counter and edge detector.
  - Parameterised by SYNC_STAGES and DEBOUNCE_COUNT.
  - Instantiated twice.
- The top level contains the FSM and the output registers only.

Test Plan (SYNC_STAGES=2, DEBOUNCE_COUNT=4):
- Player A held high for 10 cycles while cd_done_in=0 -> 7 cycles after btn_in rises: foul_out=2'b01, winner_out=2'b10, result_valid_out=1.
- cd_done_in=1, then player B pressed -> winner_out=2'b10 exactly 7 cycles after btn_in[1] rises; foul_out=0, tie_out=0.
- cd_done_in=1, both buttons rise on the same cycle -> winner_out=2'b11, tie_out=1, foul_out=0.
- cd_done_in=1, player A pulses high for 3 cycles only -> no event; outputs stay 0 and result_valid_out=0.
- Player A wins, then player B pressed -> outputs unchanged. Assert reset for 1 cycle -> all outputs 0 and FSM back in WAIT_CD.
- Player B held through reset release with cd_done_in=0 -> foul_out=2'b10, winner_out=2'b01, 7 cycles after the reset deasserts.
